// File: rtl/adc_sar_ctrl_12bit.sv
// adc_sar_ctrl_12bit: SAR sequencer for the 12-bit cap-array ADC: sample, 12 binary-search trials,
// trial-code decode to row/column/LSB enables, and start/valid result handshake.
module adc_sar_ctrl_12bit #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter bit COMP_INV = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        comp,
  output logic        busy,
  output logic        valid,
  output logic [11:0] data,
  output logic        sample,
  output logic        sample_n,
  output logic        sw,
  output logic        sw_n,
  output logic [15:0] row_n,
  output logic [15:0] rowon_n,
  output logic [15:0] rowoff_n,
  output logic [31:0] col,
  output logic [31:0] col_n,
  output logic [2:0]  en_bit_n,
  output logic        en_C0_n
);
  localparam int CW = $clog2((SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0] idx, idx_nxt;
  logic [11:0] t, t_nxt;
  logic c;
  logic [15:0] row_d, rowon_d, rowoff_d;
  logic [31:0] col_d;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    idx_nxt = idx;
    t_nxt = t;
    c = comp ^ COMP_INV;
    case (state)
      IDLE: if (start) begin
        state_nxt = SAMPLE;
        cnt_nxt = CW'(SAMPLE_CYCLES - 1);
        t_nxt = '0;
      end
      SAMPLE: if (cnt == '0) begin
        state_nxt = CONV;
        cnt_nxt = CW'(SETTLE_CYCLES - 1);
        idx_nxt = 4'd11;
        t_nxt = 12'h800;
      end else cnt_nxt = cnt - 1'b1;
      CONV: if (cnt != '0) cnt_nxt = cnt - 1'b1;
      else begin
        t_nxt[idx] = c;
        if (idx != '0) begin
          t_nxt[idx - 1'b1] = 1'b1;
          idx_nxt = idx - 1'b1;
          cnt_nxt = CW'(SETTLE_CYCLES - 1);
        end else state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
        t_nxt = '0;
      end
    endcase
  end
  // decode the code being loaded this edge so the enables change together with t
  always_comb begin
    row_d = '1;
    rowon_d = '1;
    rowoff_d = '1;
    col_d = '0;
    for (int r = 0; r < 16; r++) begin
      rowon_d[r] = r >= int'(t_nxt[11:8]);
      row_d[r] = r != int'(t_nxt[11:8]);
      rowoff_d[r] = r <= int'(t_nxt[11:8]);
    end
    for (int k = 0; k < 32; k++) col_d[k] = k < int'(t_nxt[7:3]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      t <= '0;
      busy <= 1'b0;
      valid <= 1'b0;
      data <= '0;
      sample <= 1'b0;
      sample_n <= 1'b1;
      sw <= 1'b0;
      sw_n <= 1'b1;
      en_C0_n <= 1'b1;
      row_n <= 16'hFFFE;
      rowon_n <= 16'hFFFF;
      rowoff_n <= 16'h0001;
      col <= '0;
      col_n <= '1;
      en_bit_n <= 3'b111;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      t <= t_nxt;
      busy <= state_nxt != IDLE || state == DONE;
      valid <= state == DONE;
      if (state == DONE) data <= t;
      sample <= state_nxt == SAMPLE;
      sample_n <= state_nxt != SAMPLE;
      sw <= state_nxt == SAMPLE;
      sw_n <= state_nxt != SAMPLE;
      en_C0_n <= !(state_nxt == SAMPLE || state_nxt == CONV);
      row_n <= row_d;
      rowon_n <= rowon_d;
      rowoff_n <= rowoff_d;
      col <= col_d;
      col_n <= ~col_d;
      en_bit_n <= ~t_nxt[2:0];
    end
  end
endmodule

// File: tb/tb_adc_sar_ctrl_12bit.sv
// tb_adc_sar_ctrl_12bit: directed bench; unit 0 defaults, unit 1 SAMPLE=1/SETTLE=1, unit 2 COMP_INV=1.
module tb_adc_sar_ctrl_12bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start_w = '0;
  logic [2:0] comp_w;
  logic [2:0] busy_w, valid_w, sample_w, sample_n_w, sw_w, sw_n_w, c0_w;
  logic [11:0] data_w [3];
  logic [15:0] row_n_w [3], rowon_n_w [3], rowoff_n_w [3];
  logic [31:0] col_w [3], col_n_w [3];
  logic [2:0] eb_w [3];
  logic [11:0] ana [3];
  int fmode [3];
  logic [11:0] last [3];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    adc_sar_ctrl_12bit #(
      .SAMPLE_CYCLES(g == 1 ? 1 : 4),
      .SETTLE_CYCLES(g == 1 ? 1 : 2),
      .COMP_INV(g == 2)
    ) dut (
      .clk(clk), .rst(rst), .start(start_w[g]), .comp(comp_w[g]),
      .busy(busy_w[g]), .valid(valid_w[g]), .data(data_w[g]),
      .sample(sample_w[g]), .sample_n(sample_n_w[g]), .sw(sw_w[g]), .sw_n(sw_n_w[g]),
      .row_n(row_n_w[g]), .rowon_n(rowon_n_w[g]), .rowoff_n(rowoff_n_w[g]),
      .col(col_w[g]), .col_n(col_n_w[g]), .en_bit_n(eb_w[g]), .en_C0_n(c0_w[g])
    );
  end

  // ideal capacitor DAC: rebuild the level from the enables the macro actually sees
  function automatic logic [11:0] dac(input logic [15:0] rn, input logic [31:0] cl, input logic [2:0] eb);
    logic [3:0] p;
    p = '0;
    for (int r = 0; r < 16; r++) if (!rn[r]) p = 4'(r);
    return {p, 5'($countones(cl)), ~eb};
  endfunction

  always_comb begin
    comp_w = '0;
    for (int k = 0; k < 3; k++)
      comp_w[k] = fmode[k] == 0 ? ana[k] >= dac(row_n_w[k], col_w[k], eb_w[k]) : fmode[k] == 2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int u;
    int f;
    logic [11:0] code;
    logic [11:0] exp;
    int lat;
    int samp;
  } vec_t;

  task automatic conv(input vec_t v);
    int n, ns;
    bit hold_ok;
    ana[v.u] = v.code;
    fmode[v.u] = v.f;
    @(negedge clk) start_w[v.u] = 1'b1;
    @(posedge clk);
    #1 start_w[v.u] = 1'b0;
    n = 0;
    ns = 0;
    hold_ok = 1'b1;
    while (n < 100) begin
      if (sample_w[v.u]) ns++;
      if (valid_w[v.u]) break;
      if (data_w[v.u] !== last[v.u]) hold_ok = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    chk($sformatf("latency u%0d code %h", v.u, v.code), n, v.lat);
    chk($sformatf("data u%0d code %h", v.u, v.code), data_w[v.u], v.exp);
    chk($sformatf("sample_len u%0d", v.u), ns, v.samp);
    chk($sformatf("data_hold u%0d", v.u), hold_ok, 1);
    last[v.u] = v.exp;
    @(posedge clk);
    #1 chk($sformatf("after_valid u%0d", v.u), {busy_w[v.u], valid_w[v.u]}, 0);
  endtask

  vec_t tbl [11];
  int pos [$];
  int n;

  initial begin
    tbl[0]  = '{0, 0, 12'hA5C, 12'hA5C, 29, 4};
    tbl[1]  = '{0, 0, 12'h000, 12'h000, 29, 4};
    tbl[2]  = '{0, 0, 12'hFFF, 12'hFFF, 29, 4};
    tbl[3]  = '{0, 1, 12'h000, 12'h000, 29, 4};
    tbl[4]  = '{0, 2, 12'h000, 12'hFFF, 29, 4};
    tbl[5]  = '{0, 0, 12'h800, 12'h800, 29, 4};
    tbl[6]  = '{0, 0, 12'h7FF, 12'h7FF, 29, 4};
    tbl[7]  = '{1, 0, 12'h001, 12'h001, 14, 1};
    tbl[8]  = '{1, 0, 12'hA5C, 12'hA5C, 14, 1};
    tbl[9]  = '{2, 1, 12'h000, 12'hFFF, 29, 4};
    tbl[10] = '{2, 2, 12'h000, 12'h000, 29, 4};
    for (int k = 0; k < 3; k++) begin
      ana[k] = '0;
      fmode[k] = 1;
      last[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy/valid", {busy_w, valid_w}, 0);
    chk("rst data", data_w[0], 12'h000);
    chk("rst sample/sw", {sample_w[0], sample_n_w[0], sw_w[0], sw_n_w[0], c0_w[0]}, 5'b01011);
    chk("rst rows", {rowon_n_w[0], row_n_w[0], rowoff_n_w[0]}, {16'hFFFF, 16'hFFFE, 16'h0001});
    chk("rst cols", {col_w[0], col_n_w[0]}, {32'h0, 32'hFFFFFFFF});
    chk("rst en_bit_n", eb_w[0], 3'b111);
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 11; k++) conv(tbl[k]);

    // decode of the first trial (0x800) and the last trial (0x12B) of a 0x12B conversion
    ana[0] = 12'h12B;
    fmode[0] = 0;
    @(negedge clk) start_w[0] = 1'b1;
    @(posedge clk);
    #1 start_w[0] = 1'b0;
    n = 0;
    while (n < 100 && !valid_w[0]) begin
      if (n == 4) begin
        chk("dec800 rows", {rowon_n_w[0], row_n_w[0], rowoff_n_w[0]}, {16'hFF00, 16'hFEFF, 16'h01FF});
        chk("dec800 col/bits", {col_w[0], eb_w[0]}, {32'h0, 3'b111});
      end
      if (n == 26) begin
        chk("dec12B rows", {rowon_n_w[0], row_n_w[0], rowoff_n_w[0]}, {16'hFFFE, 16'hFFFD, 16'h0003});
        chk("dec12B col", {col_w[0], col_n_w[0]}, {32'h0000001F, 32'hFFFFFFE0});
        chk("dec12B en_bit_n/C0", {eb_w[0], c0_w[0]}, {3'b100, 1'b0});
      end
      @(posedge clk);
      #1 n++;
    end
    chk("dec12B latency", n, 29);
    chk("dec12B data", data_w[0], 12'h12B);
    last[0] = 12'h12B;

    // start held high: requests during CONV/DONE are ignored, valids 30 cycles apart
    ana[0] = 12'h3C5;
    @(negedge clk) start_w[0] = 1'b1;
    @(posedge clk);
    #1 n = 0;
    while (n < 65) begin
      if (valid_w[0]) pos.push_back(n);
      @(posedge clk);
      #1 n++;
    end
    start_w[0] = 1'b0;
    chk("held valid count", pos.size(), 2);
    chk("held first valid", pos.size() > 0 ? pos[0] : -1, 29);
    chk("held second valid", pos.size() > 1 ? pos[1] : -1, 59);
    chk("held data", data_w[0], 12'h3C5);
    n = 0;
    while (n < 100 && busy_w[0]) begin
      @(posedge clk);
      #1 n++;
    end
    chk("held drains", busy_w[0], 0);

    // asynchronous reset mid-CONV aborts without a valid pulse
    ana[0] = 12'hA5C;
    @(negedge clk) start_w[0] = 1'b1;
    @(posedge clk);
    #1 start_w[0] = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async rst busy", busy_w[0], 0);
    @(posedge clk);
    #1;
    chk("midrst busy/valid/sample_n", {busy_w[0], valid_w[0], sample_n_w[0]}, 3'b001);
    chk("midrst rows", {row_n_w[0], rowoff_n_w[0]}, {16'hFFFE, 16'h0001});
    chk("midrst col/data", {col_w[0], data_w[0]}, {32'h0, 12'h000});
    @(negedge clk) rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 if (valid_w[0] || busy_w[0]) n++;
    end
    chk("no valid after rst", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
